// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// master: pipeline side (drives hazard sources, receives stall/flush/bubble controls).
// slave:  controller side.
interface pipeline_hazard_controller_if;
    logic        imem_busywait;
    logic        dmem_busywait;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_is_div;
    logic        branch_taken;

    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_bubble;
    logic        ex_mem_stall;
    logic        ex_mem_bubble;
    logic        mem_wb_stall;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output imem_busywait, dmem_busywait, id_rs1, id_rs2, ex_rd,
               ex_mem_read, ex_is_div, branch_taken,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_stall, ex_mem_bubble, mem_wb_stall, ctrl_state,
               stall_cycles, flush_count
    );

    modport slave (
        input  imem_busywait, dmem_busywait, id_rs1, id_rs2, ex_rd,
               ex_mem_read, ex_is_div, branch_taken,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
               ex_mem_stall, ex_mem_bubble, mem_wb_stall, ctrl_state,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: decodes memory waits, multi-cycle divides, taken
// branches, load-use and fetch waits into per-register stall/flush/bubble controls.
// Performance counters (stall_cycles, flush_count) exist only when the macro
// HAZARD_PERF_CNT_EN is defined; otherwise both outputs read as zero.
module pipeline_hazard_controller #(
    parameter int unsigned DIV_LATENCY = 32
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave hz
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDivWait = 2'd1,
        StMemWait = 2'd2
    } state_e;

    // Counter value loaded on the trigger cycle; the trigger cycle itself is the first stall.
    localparam logic [7:0] DivLoad = 8'(DIV_LATENCY - 1);

    state_e     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    // Set when a divide has completed but the divide is still sitting in EX,
    // so the release cycle does not start a second divide.
    logic       div_done_q, div_done_d;

    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_bubble;
    logic ex_mem_stall;
    logic ex_mem_bubble;
    logic mem_wb_stall;
    logic branch_act;
    logic load_use;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

    // Next-state and stall/flush/bubble decode, in hazard priority order.
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        div_done_d    = div_done_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_stall  = 1'b0;
        branch_act    = 1'b0;

        if (reset) begin
            // Outputs stay quiet; the state register handles the reset itself.
        end else if (hz.dmem_busywait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
            if (state_q == StDivWait) begin
                // The divider keeps running underneath a data-memory wait.
                div_cnt_d = div_cnt_q - 8'd1;
                if (div_cnt_q <= 8'd1) begin
                    state_d    = StMemWait;
                    div_cnt_d  = 8'd0;
                    div_done_d = 1'b1;
                end
            end else begin
                state_d = StMemWait;
            end
        end else if (state_q == StDivWait) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            ex_mem_bubble = 1'b1;
            div_cnt_d     = div_cnt_q - 8'd1;
            if (div_cnt_q <= 8'd1) begin
                state_d    = StRun;
                div_cnt_d  = 8'd0;
                div_done_d = 1'b1;
            end
        end else begin
            // RUN, or the first MEM_WAIT cycle with the data memory ready.
            state_d    = StRun;
            div_done_d = 1'b0;
            if (hz.ex_is_div && !div_done_q) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                ex_mem_bubble = 1'b1;
                state_d       = StDivWait;
                div_cnt_d     = DivLoad;
                div_done_d    = 1'b0;
            end else if (hz.branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                branch_act   = 1'b1;
            end else if (load_use) begin
                // Stall on IF/ID wins over a fetch-wait flush of the same register.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (hz.imem_busywait) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            div_cnt_q  <= 8'd0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_done_q <= div_done_d;
        end
    end

    assign hz.pc_stall      = pc_stall;
    assign hz.if_id_stall   = if_id_stall;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_stall   = id_ex_stall;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.ex_mem_stall  = ex_mem_stall;
    assign hz.ex_mem_bubble = ex_mem_bubble;
    assign hz.mem_wb_stall  = mem_wb_stall;
    assign hz.ctrl_state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (branch_act && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`else
    logic perf_unused;
    assign perf_unused     = branch_act;
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: one instance with DIV_LATENCY=4
// for the main sequence, one with DIV_LATENCY=16 for reset in the middle of a divide.
module tb_pipeline_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    // Output vector order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
    // ex_mem_stall, ex_mem_bubble, mem_wb_stall.
    localparam logic [7:0] ONone = 8'b0000_0000;
    localparam logic [7:0] OLu   = 8'b1100_1000;
    localparam logic [7:0] ODiv  = 8'b1101_0110;
    localparam logic [7:0] OMem  = 8'b1101_0101;
    localparam logic [7:0] OBr   = 8'b0010_1000;
    localparam logic [7:0] OIm   = 8'b1010_0000;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   n_tests;
    int   n_fail;
    int   exp_stalls;
    int   exp_flush;

    pipeline_hazard_controller_if hz_a ();
    pipeline_hazard_controller_if hz_b ();

    pipeline_hazard_controller #(.DIV_LATENCY(4)) u_dut_a (
        .clk   (clk),
        .reset (reset_a),
        .hz    (hz_a)
    );

    pipeline_hazard_controller #(.DIV_LATENCY(16)) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .hz    (hz_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic imem, input logic dmem, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic mread,
                         input logic div, input logic br);
        hz_a.imem_busywait = imem;
        hz_a.dmem_busywait = dmem;
        hz_a.id_rs1        = rs1;
        hz_a.id_rs2        = rs2;
        hz_a.ex_rd         = rd;
        hz_a.ex_mem_read   = mread;
        hz_a.ex_is_div     = div;
        hz_a.branch_taken  = br;
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: outputs/state got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] exp, input logic [1:0] st);
        check_vec(tag, {hz_a.pc_stall, hz_a.if_id_stall, hz_a.if_id_flush, hz_a.id_ex_stall,
                        hz_a.id_ex_bubble, hz_a.ex_mem_stall, hz_a.ex_mem_bubble,
                        hz_a.mem_wb_stall, hz_a.ctrl_state}, {exp, st});
        // Every check_a is followed by a clock edge with the same inputs.
        if (!reset_a && exp[7]) exp_stalls++;
    endtask

    task automatic check_b(input string tag, input logic [7:0] exp, input logic [1:0] st);
        check_vec(tag, {hz_b.pc_stall, hz_b.if_id_stall, hz_b.if_id_flush, hz_b.id_ex_stall,
                        hz_b.id_ex_bubble, hz_b.ex_mem_stall, hz_b.ex_mem_bubble,
                        hz_b.mem_wb_stall, hz_b.ctrl_state}, {exp, st});
    endtask

    task automatic check_cnt_a(input string tag);
        check32({tag, "_stall_cycles"}, hz_a.stall_cycles, PerfEn ? 32'(exp_stalls) : 32'd0);
        check32({tag, "_flush_count"}, hz_a.flush_count, PerfEn ? 32'(exp_flush) : 32'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        exp_stalls = 0;
        exp_flush  = 0;
        reset_a    = 1'b1;
        reset_b    = 1'b1;
        hz_b.imem_busywait = 1'b0;
        hz_b.dmem_busywait = 1'b0;
        hz_b.id_rs1        = 5'd0;
        hz_b.id_rs2        = 5'd0;
        hz_b.ex_rd         = 5'd0;
        hz_b.ex_mem_read   = 1'b0;
        hz_b.ex_is_div     = 1'b0;
        hz_b.branch_taken  = 1'b0;
        // Every hazard source asserted while in reset: outputs must stay quiet.
        set_a(1, 1, 5, 5, 5, 1, 1, 1);
        tick;
        tick;
        check_a("reset_gate", ONone, 2'd0);
        check_cnt_a("reset");

        reset_a = 1'b0;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        check_a("idle", ONone, 2'd0);
        tick;

        set_a(0, 0, 3, 5, 5, 1, 0, 0);
        check_a("load_use_rs2", OLu, 2'd0);
        tick;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        check_a("load_use_one_cycle", ONone, 2'd0);
        tick;
        set_a(0, 0, 0, 0, 0, 1, 0, 0);
        check_a("load_use_rd0", ONone, 2'd0);
        tick;
        set_a(0, 0, 7, 2, 7, 1, 0, 0);
        check_a("load_use_rs1", OLu, 2'd0);
        tick;
        set_a(0, 0, 1, 2, 3, 1, 0, 0);
        check_a("load_no_match", ONone, 2'd0);
        tick;
        set_a(1, 0, 0, 0, 0, 0, 0, 0);
        check_a("imem_wait", OIm, 2'd0);
        tick;
        set_a(1, 0, 4, 9, 9, 1, 0, 0);
        check_a("load_use_imem", OLu, 2'd0);
        tick;
        check_cnt_a("pre_branch");

        set_a(1, 0, 4, 9, 9, 1, 0, 1);
        check_a("branch_over_lu_imem", OBr, 2'd0);
        exp_flush++;
        tick;
        check_cnt_a("post_branch");

        // Divide with DIV_LATENCY=4: 4 stall cycles, 3 of them in DIV_WAIT.
        set_a(0, 0, 0, 0, 0, 0, 1, 0);
        check_a("div_trigger", ODiv, 2'd0);
        tick;
        check_a("div_wait_1", ODiv, 2'd1);
        tick;
        check_a("div_wait_2", ODiv, 2'd1);
        tick;
        check_a("div_wait_3", ODiv, 2'd1);
        tick;
        check_a("div_release_no_retrigger", ONone, 2'd0);
        tick;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        check_a("div_after", ONone, 2'd0);
        tick;
        check_cnt_a("post_div");

        // Data-memory wait arriving while the divide counter is 1.
        set_a(0, 0, 0, 0, 0, 0, 1, 0);
        check_a("div2_trigger", ODiv, 2'd0);
        tick;
        check_a("div2_wait_3", ODiv, 2'd1);
        tick;
        check_a("div2_wait_2", ODiv, 2'd1);
        tick;
        set_a(0, 1, 0, 0, 0, 0, 1, 0);
        check_a("div2_dmem_cnt1", OMem, 2'd1);
        tick;
        check_a("div2_memwait_a", OMem, 2'd2);
        tick;
        check_a("div2_memwait_b", OMem, 2'd2);
        tick;
        set_a(0, 0, 0, 0, 0, 0, 1, 0);
        check_a("div2_mem_release", ONone, 2'd2);
        tick;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        check_a("div2_back_run", ONone, 2'd0);
        tick;
        check_cnt_a("post_div2");

        // Branch held through a data-memory wait, acted on at release.
        set_a(1, 1, 4, 9, 9, 1, 0, 1);
        check_a("dmem_over_branch", OMem, 2'd0);
        tick;
        check_a("memwait_branch_held", OMem, 2'd2);
        tick;
        set_a(1, 0, 4, 9, 9, 1, 0, 1);
        check_a("memwait_branch_release", OBr, 2'd2);
        exp_flush++;
        tick;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        check_a("after_mem_branch", ONone, 2'd0);
        tick;
        check_cnt_a("post_mem_branch");

        // Reset in the middle of MEM_WAIT.
        set_a(0, 1, 0, 0, 0, 0, 0, 0);
        check_a("memwait_enter", OMem, 2'd0);
        tick;
        check_a("memwait_held", OMem, 2'd2);
        reset_a = 1'b1;
        #1;
        check_a("memwait_reset_gate", ONone, 2'd2);
        tick;
        exp_stalls = 0;
        exp_flush  = 0;
        check_a("memwait_reset_abort", ONone, 2'd0);
        check_cnt_a("memwait_reset");
        reset_a = 1'b0;
        set_a(0, 0, 0, 0, 0, 0, 0, 0);
        check_a("memwait_reset_idle", ONone, 2'd0);
        tick;

        // DIV_LATENCY=16 instance: reset while the divide counter is 10.
        reset_b = 1'b0;
        hz_b.ex_is_div = 1'b1;
        #1;
        check_b("b_div_trigger", ODiv, 2'd0);
        tick;
        for (int i = 0; i < 5; i++) begin
            check_b("b_div_wait", ODiv, 2'd1);
            tick;
        end
        check_b("b_div_wait_cnt10", ODiv, 2'd1);
        reset_b = 1'b1;
        #1;
        check_b("b_reset_gate", ONone, 2'd1);
        tick;
        check_b("b_reset_abort", ONone, 2'd0);
        check32("b_reset_stall_cycles", hz_b.stall_cycles, 32'd0);
        check32("b_reset_flush_count", hz_b.flush_count, 32'd0);
        reset_b = 1'b0;
        #1;
        check_b("b_retrigger_after_reset", ODiv, 2'd0);
        tick;
        check_b("b_div_wait_after_reset", ODiv, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
